// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - round-robin arbiter/sequencer for a single-port synchronous data memory
//
// Purpose:
//   Shares the one read/write port of a synchronous data memory between two
//   requesters. A request is granted in the same cycle it is presented.
//   When both requesters ask in the same cycle, the port that was not granted
//   most recently wins. Read data comes back one cycle after the grant.
//   Optional feature, macro MEM_ARB_INIT_CLEAR_EN: after every reset the block
//   writes zero to addresses 0..DEPTH-1. It accepts no traffic until that
//   zero-fill is done.
//
// Ports:
//   clk              rising-edge clock
//   rst              asynchronous active-high reset
//   ready            high while requests are accepted
//   p0_req/p1_req    request, held until granted
//   p0_we/p1_we      1 = write, 0 = read
//   p0_addr/p1_addr  request address
//   p0_wdata/p1_wdata write data
//   p0_gnt/p1_gnt    request accepted this cycle
//   p0_rvalid/p1_rvalid read data valid (one cycle after a read grant)
//   p0_rdata/p1_rdata read data (both carry mem_dataout)
//   mem_writeenable  memory write enable
//   mem_readenable   memory read enable
//   mem_address      memory address
//   mem_datain       memory write data
//   mem_dataout      registered read data from memory
module mem_arbiter #(
  parameter int DEPTH  = 128,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  output logic              ready,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              mem_writeenable,
  output logic              mem_readenable,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_datain,
  input  logic [DATA_W-1:0] mem_dataout
);

  // A zero-depth memory has nothing to clear or arbitrate for.
  generate
    if (DEPTH < 1) begin : g_bad_depth
      $error("mem_arbiter: DEPTH must be at least 1");
    end
  endgenerate

  logic       run;       // arbitration allowed this cycle
  logic       gnt0;
  logic       gnt1;
  logic       last_gnt;  // port granted most recently (1 = port 1)
  logic [1:0] rd_pend;   // bit n: port n was granted a read last cycle

`ifdef MEM_ARB_INIT_CLEAR_EN
  typedef enum logic {
    ST_INIT,
    ST_RUN
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [ADDR_W-1:0] clr_addr;
  logic [ADDR_W-1:0] clr_addr_nx;
  logic              clearing;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_INIT;
      clr_addr <= '0;
    end else begin
      state    <= state_nx;
      clr_addr <= clr_addr_nx;
    end
  end

  always_comb begin
    state_nx    = state;
    clr_addr_nx = clr_addr;
    if (state == ST_INIT) begin
      if (clr_addr == ADDR_W'(DEPTH - 1)) begin
        state_nx    = ST_RUN;
        clr_addr_nx = '0;
      end else begin
        clr_addr_nx = clr_addr + ADDR_W'(1);
      end
    end
  end

  // Reset has priority: these terms drop the moment rst rises.
  assign clearing = (state == ST_INIT) && !rst;
  assign run      = (state == ST_RUN) && !rst;
`else
  assign run = !rst;
`endif

  assign ready = run;

  // If only one port requests, that port wins.
  // If both request, the port that did not win last time wins.
  assign gnt0 = run && p0_req && (!p1_req || last_gnt);
  assign gnt1 = run && p1_req && (!p0_req || !last_gnt);

  assign p0_gnt = gnt0;
  assign p1_gnt = gnt1;

  always_comb begin
    mem_writeenable = 1'b0;
    mem_readenable  = 1'b0;
    mem_address     = '0;
    mem_datain      = '0;
    if (gnt0) begin
      mem_writeenable = p0_we;
      mem_readenable  = !p0_we;
      mem_address     = p0_addr;
      mem_datain      = p0_wdata;
    end else if (gnt1) begin
      mem_writeenable = p1_we;
      mem_readenable  = !p1_we;
      mem_address     = p1_addr;
      mem_datain      = p1_wdata;
    end
`ifdef MEM_ARB_INIT_CLEAR_EN
    // No grant can occur while clearing, so this override never collides.
    if (clearing) begin
      mem_writeenable = 1'b1;
      mem_address     = clr_addr;
      mem_datain      = '0;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_gnt <= 1'b1;
      rd_pend  <= 2'b00;
    end else begin
      if (gnt0 || gnt1) begin
        last_gnt <= gnt1;
      end
      rd_pend <= {gnt1 && !p1_we, gnt0 && !p0_we};
    end
  end

  // The memory registers its read data, so the data lines up with rd_pend.
  assign p0_rvalid = rd_pend[0];
  assign p1_rvalid = rd_pend[1];
  assign p0_rdata  = mem_dataout;
  assign p1_rdata  = mem_dataout;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter
module tb_mem_arbiter;
  localparam int AW    = 32;
  localparam int DW    = 32;
  localparam int DEPTH = 128;

`ifdef MEM_ARB_INIT_CLEAR_EN
  localparam logic [31:0] E5 = 32'h0;
`else
  localparam logic [31:0] E5 = 32'hA5A5_0005;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ready;
  logic          p0_req = 1'b0, p0_we = 1'b0;
  logic [AW-1:0] p0_addr = '0;
  logic [DW-1:0] p0_wdata = '0;
  logic          p0_gnt, p0_rvalid;
  logic [DW-1:0] p0_rdata;
  logic          p1_req = 1'b0, p1_we = 1'b0;
  logic [AW-1:0] p1_addr = '0;
  logic [DW-1:0] p1_wdata = '0;
  logic          p1_gnt, p1_rvalid;
  logic [DW-1:0] p1_rdata;
  logic          mem_writeenable, mem_readenable;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .ready(ready),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_writeenable(mem_writeenable), .mem_readenable(mem_readenable),
    .mem_address(mem_address), .mem_datain(mem_datain), .mem_dataout(mem_dataout)
  );

  // Single-port synchronous memory with registered read data.
  // It is pre-filled with a recognisable pattern so that the zero-fill is observable.
  logic [DW-1:0] mem [DEPTH];
  bit            mem_init_done = 1'b0;
  always @(posedge clk) begin
    if (!mem_init_done) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 32'hA5A5_0000 | 32'(i);
      mem_init_done <= 1'b1;
    end else begin
      if (mem_writeenable) mem[mem_address[6:0]] <= mem_datain;
      if (mem_readenable) mem_dataout <= mem[mem_address[6:0]];
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  typedef struct {
    logic r0, w0; logic [31:0] a0, d0;
    logic r1, w1; logic [31:0] a1, d1;
    logic g0, g1, v0, v1; logic [31:0] rd;
    logic mwe, mre; logic [31:0] maddr, mdin;
  } vec_t;

  function automatic vec_t mk(
    input logic r0, w0, input logic [31:0] a0, d0,
    input logic r1, w1, input logic [31:0] a1, d1,
    input logic g0, g1, v0, v1, input logic [31:0] rd,
    input logic mwe, mre, input logic [31:0] maddr, mdin);
    vec_t v;
    v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.rd = rd;
    v.mwe = mwe; v.mre = mre; v.maddr = maddr; v.mdin = mdin;
    return v;
  endfunction

  task automatic drive(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  // Zero-fill check: DEPTH consecutive zero writes from address 0, no grants, then ready.
  task automatic check_clear();
    for (int i = 0; i < DEPTH; i++) begin
      #1;
      chk("clr_we", 32'(mem_writeenable), 32'd1);
      chk("clr_addr", mem_address, 32'(i));
      chk("clr_data", mem_datain, 32'd0);
      chk("clr_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
      chk("clr_ready", 32'(ready), 32'd0);
      @(negedge clk);
    end
  endtask

  // Reference model: round-robin winner, a word array, and one pending read.
  logic [31:0] ref_mem [16];
  int          ref_last = 1;
  bit          exp_v0 = 1'b0, exp_v1 = 1'b0;
  logic [31:0] exp_rd = '0;

  task automatic rstep(input logic r0, w0, input logic [31:0] a0, d0,
                       input logic r1, w1, input logic [31:0] a1, d1);
    int          win;
    logic        wwe;
    logic [31:0] wa, wd;
    @(negedge clk);
    drive(r0, w0, a0, d0, r1, w1, a1, d1);
    #1;
    chk("rnd_rvalid0", 32'(p0_rvalid), 32'(exp_v0));
    chk("rnd_rvalid1", 32'(p1_rvalid), 32'(exp_v1));
    if (exp_v0) chk("rnd_rdata0", p0_rdata, exp_rd);
    if (exp_v1) chk("rnd_rdata1", p1_rdata, exp_rd);
    win = -1;
    if (r0 && r1) win = (ref_last == 0) ? 1 : 0;
    else if (r0)  win = 0;
    else if (r1)  win = 1;
    chk("rnd_gnt0", 32'(p0_gnt), 32'(win == 0));
    chk("rnd_gnt1", 32'(p1_gnt), 32'(win == 1));
    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    if (win >= 0) begin
      wwe = (win == 0) ? w0 : w1;
      wa  = (win == 0) ? a0 : a1;
      wd  = (win == 0) ? d0 : d1;
      chk("rnd_mem_we", 32'(mem_writeenable), 32'(wwe));
      chk("rnd_mem_addr", mem_address, wa);
      ref_last = win;
      if (wwe) ref_mem[wa[3:0]] = wd;
      else begin
        exp_rd = ref_mem[wa[3:0]];
        if (win == 0) exp_v0 = 1'b1; else exp_v1 = 1'b1;
      end
    end else begin
      chk("rnd_mem_idle", {30'd0, mem_writeenable, mem_readenable}, 32'd0);
    end
  endtask

  vec_t tbl[$];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Table: each row is one cycle with its inputs and the outputs expected in that cycle.
    //             r0 w0 a0  d0            r1 w1 a1 d1       g0 g1 v0 v1 rd            we re addr din
    tbl.push_back(mk(1, 0, 5,  0,            0, 0, 0, 0,       1, 0, 0, 0, 0,            0, 1, 5,  0));
    tbl.push_back(mk(1, 1, 10, 32'hDEADBEEF, 0, 0, 0, 0,       1, 0, 1, 0, E5,           1, 0, 10, 32'hDEADBEEF));
    tbl.push_back(mk(1, 0, 10, 0,            0, 0, 0, 0,       1, 0, 0, 0, 0,            0, 1, 10, 0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0, 0,       0, 0, 1, 0, 32'hDEADBEEF, 0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 1,  32'h1111,     0, 0, 0, 0,       1, 0, 0, 0, 0,            1, 0, 1,  32'h1111));
    tbl.push_back(mk(0, 0, 0,  0,            1, 1, 2, 32'h2222, 0, 1, 0, 0, 0,           1, 0, 2,  32'h2222));
    tbl.push_back(mk(1, 0, 1,  0,            1, 0, 2, 0,       1, 0, 0, 0, 0,            0, 1, 1,  0));
    tbl.push_back(mk(1, 0, 1,  0,            1, 0, 2, 0,       0, 1, 1, 0, 32'h1111,     0, 1, 2,  0));
    tbl.push_back(mk(1, 0, 1,  0,            1, 0, 2, 0,       1, 0, 0, 1, 32'h2222,     0, 1, 1,  0));
    tbl.push_back(mk(1, 0, 1,  0,            1, 0, 2, 0,       0, 1, 1, 0, 32'h1111,     0, 1, 2,  0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0, 0,       0, 0, 0, 1, 32'h2222,     0, 0, 0,  0));
    tbl.push_back(mk(0, 0, 0,  0,            1, 1, 3, 32'h55,  0, 1, 0, 0, 0,            1, 0, 3,  32'h55));
    tbl.push_back(mk(1, 0, 3,  0,            0, 0, 0, 0,       1, 0, 0, 0, 0,            0, 1, 3,  0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0, 0,       0, 0, 1, 0, 32'h55,       0, 0, 0,  0));
    tbl.push_back(mk(1, 1, 4,  32'h0A,       1, 0, 3, 0,       0, 1, 0, 0, 0,            0, 1, 3,  0));
    tbl.push_back(mk(1, 1, 4,  32'h0A,       1, 0, 3, 0,       1, 0, 0, 1, 32'h55,       1, 0, 4,  32'h0A));
    tbl.push_back(mk(0, 0, 0,  0,            1, 0, 4, 0,       0, 1, 0, 0, 0,            0, 1, 4,  0));
    tbl.push_back(mk(0, 0, 0,  0,            0, 0, 0, 0,       0, 0, 0, 1, 32'h0A,       0, 0, 0,  0));

    // Reset state: both requests are asserted, yet nothing may be granted.
    drive(1, 0, 7, 0, 1, 1, 8, 32'h77);
    #2;
    chk("rst_ready", 32'(ready), 32'd0);
    chk("rst_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk("rst_rvalid", {30'd0, p1_rvalid, p0_rvalid}, 32'd0);
    chk("rst_mem_en", {30'd0, mem_writeenable, mem_readenable}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    drive(1, 0, 5, 0, 0, 0, 0, 0);
    rst = 1'b0;
`ifdef MEM_ARB_INIT_CLEAR_EN
    check_clear();
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0, tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      #1;
      if (i == 0) chk("ready_run", 32'(ready), 32'd1);
      chk($sformatf("v%0d_gnt0", i), 32'(p0_gnt), 32'(tbl[i].g0));
      chk($sformatf("v%0d_gnt1", i), 32'(p1_gnt), 32'(tbl[i].g1));
      chk($sformatf("v%0d_rvalid0", i), 32'(p0_rvalid), 32'(tbl[i].v0));
      chk($sformatf("v%0d_rvalid1", i), 32'(p1_rvalid), 32'(tbl[i].v1));
      if (tbl[i].v0) chk($sformatf("v%0d_rdata0", i), p0_rdata, tbl[i].rd);
      if (tbl[i].v1) chk($sformatf("v%0d_rdata1", i), p1_rdata, tbl[i].rd);
      chk($sformatf("v%0d_mem_we", i), 32'(mem_writeenable), 32'(tbl[i].mwe));
      chk($sformatf("v%0d_mem_re", i), 32'(mem_readenable), 32'(tbl[i].mre));
      chk($sformatf("v%0d_mem_addr", i), mem_address, tbl[i].maddr);
      chk($sformatf("v%0d_mem_din", i), mem_datain, tbl[i].mdin);
    end

    // Reset shortly after a p1 read grant: the outstanding read is discarded.
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 0, 10, 0);
    #1;
    chk("mid_gnt1", 32'(p1_gnt), 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    p0_req = 1'b1;
    #1;
    chk("mid_rvalid1", 32'(p1_rvalid), 32'd0);
    chk("mid_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    chk("mid_mem_en", {30'd0, mem_writeenable, mem_readenable}, 32'd0);
    chk("mid_ready", 32'(ready), 32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      #1;
      chk("mid_hold_rvalid1", 32'(p1_rvalid), 32'd0);
      chk("mid_hold_gnt", {30'd0, p1_gnt, p0_gnt}, 32'd0);
    end
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;
`ifdef MEM_ARB_INIT_CLEAR_EN
    check_clear();
    #1;
    chk("post_clear_ready", 32'(ready), 32'd1);
`else
    #1;
    chk("post_rst_ready", 32'(ready), 32'd1);
`endif
    chk("post_rst_rvalid1", 32'(p1_rvalid), 32'd0);

    // Randomized traffic against the reference model, after every word in 0..15 has been written.
    ref_last = 1;
    exp_v0 = 1'b0;
    exp_v1 = 1'b0;
    for (int a = 0; a < 16; a++) rstep(1, 1, 32'(a), $urandom, 0, 0, 0, 0);
    for (int n = 0; n < 400; n++) begin
      rstep(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom,
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 32'($urandom_range(0, 15)), $urandom);
    end
    rstep(0, 0, 0, 0, 0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
